// File: rtl/sram_stream_pkg.sv
// ---------------------------------------------------------------------------
// sram_stream_pkg
//   Shared definitions for the SramTop byte-stream side (io_Wr_N_* / io_Rd_N_*).
//   Used by pkt_stream_tx today and intended for the matching pkt_stream_rx
//   checker on the read side.
//
//   Contents:
//     STREAM_DATA_W / STREAM_LEN_W : default payload and length widths
//     state_e                      : transmitter FSM encoding (IDLE/SEND/GAP)
//     stream_beat_t                : one stream beat {data, sop, eop}
// ---------------------------------------------------------------------------
package sram_stream_pkg;

   localparam int STREAM_DATA_W = 8;
   localparam int STREAM_LEN_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_e;

   typedef struct packed {
      logic [STREAM_DATA_W-1:0] data;
      logic                     sop;
      logic                     eop;
   } stream_beat_t;

endpackage

// File: rtl/pkt_stream_tx.sv
// ---------------------------------------------------------------------------
// pkt_stream_tx
//   Command-driven packet source for one SramTop write port. Each accepted
//   command produces one framed packet of cmd_len+1 incrementing bytes
//   starting at cmd_seed, followed by cmd_gap idle cycles before the next
//   command can be taken.
//
//   Handshakes: a transfer happens on a rising clock edge where both valid
//   and ready are high. A source holding valid keeps its payload stable until
//   that edge; ready may change freely and has no effect while valid is low.
//
//   Ports:
//     clock, reset         clock and asynchronous active-low reset
//     cmd_valid/cmd_ready  command handshake (accepted only in IDLE)
//     cmd_len              beats minus one
//     cmd_seed             first payload byte
//     cmd_gap              idle cycles after the eop handshake
//     out_valid/out_ready  beat handshake towards io_Wr_N_*
//     out_data/sop/eop     beat payload and framing
//     busy                 FSM is not IDLE
//     pkt_cnt              packets completed (eop handshakes), wrapping
//     state_dbg            current FSM state, for checkers and debug
// ---------------------------------------------------------------------------
module pkt_stream_tx
   import sram_stream_pkg::*;
#(
   parameter int DATA_W = STREAM_DATA_W,
   parameter int LEN_W  = STREAM_LEN_W,
   parameter int GAP_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] cmd_seed,
   input  logic [GAP_W-1:0]  cmd_gap,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sop,
   output logic              out_eop,
   input  logic              out_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic [1:0]        state_dbg
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_SEND = SEND;
   localparam logic [1:0] ST_GAP  = GAP;

   logic [1:0]        state_q,    state_d;
   logic [LEN_W-1:0]  len_q,      len_d;
   logic [GAP_W-1:0]  gap_q,      gap_d;
   logic [LEN_W-1:0]  beat_q,     beat_d;
   logic [GAP_W-1:0]  gap_cnt_q,  gap_cnt_d;
   logic [DATA_W-1:0] data_q,     data_d;
   logic              sop_q,      sop_d;
   logic              eop_q,      eop_d;
   logic              valid_q,    valid_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   // Holds cmd_ready low while reset is asserted even though the FSM sits
   // in IDLE; it rises on the first clock edge after release.
   logic              ready_en_q, ready_en_d;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      gap_d      = gap_q;
      beat_d     = beat_q;
      gap_cnt_d  = gap_cnt_q;
      data_d     = data_q;
      sop_d      = sop_q;
      eop_d      = eop_q;
      valid_d    = valid_q;
      cnt_d      = cnt_q;
      ready_en_d = 1'b1;
      cmd_ready  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cmd_ready = ready_en_q;
            if (cmd_valid && ready_en_q) begin
               len_d   = cmd_len;
               gap_d   = cmd_gap;
               beat_d  = '0;
               // The first beat is registered here so it is valid the
               // cycle right after the command handshake.
               data_d  = cmd_seed;
               sop_d   = 1'b1;
               eop_d   = (cmd_len == '0);
               valid_d = 1'b1;
               state_d = ST_SEND;
            end
         end

         ST_SEND: begin
            // Without a handshake every output register simply holds.
            if (valid_q && out_ready) begin
               if (eop_q) begin
                  valid_d = 1'b0;
                  sop_d   = 1'b0;
                  eop_d   = 1'b0;
                  cnt_d   = cnt_q + CNT_W'(1);
                  if (gap_q == '0) begin
                     state_d = ST_IDLE;
                  end else begin
                     gap_cnt_d = gap_q;
                     state_d   = ST_GAP;
                  end
               end else begin
                  beat_d = beat_q + LEN_W'(1);
                  data_d = data_q + DATA_W'(1);
                  sop_d  = 1'b0;
                  eop_d  = ((beat_q + LEN_W'(1)) == len_q);
               end
            end
         end

         ST_GAP: begin
            // Loaded with gap on the eop handshake; reaching IDLE after the
            // count of 1 gives exactly gap idle cycles before cmd_ready.
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
            if (gap_cnt_q == GAP_W'(1)) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         gap_q      <= '0;
         beat_q     <= '0;
         gap_cnt_q  <= '0;
         data_q     <= '0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         valid_q    <= 1'b0;
         cnt_q      <= '0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         gap_q      <= gap_d;
         beat_q     <= beat_d;
         gap_cnt_q  <= gap_cnt_d;
         data_q     <= data_d;
         sop_q      <= sop_d;
         eop_q      <= eop_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
         ready_en_q <= ready_en_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_sop   = sop_q;
   assign out_eop   = eop_q;
   assign busy      = (state_q != ST_IDLE);
   assign pkt_cnt   = cnt_q;
   assign state_dbg = state_q;

endmodule
